// File: rtl/qpsk_ctrl_pkg.sv
// Shared types, widths and saturating/abs helpers for the QPSK carrier-recovery loop.
package qpsk_ctrl_pkg;

  localparam int unsigned DW       = 14;
  localparam int unsigned INT_W    = 24;
  localparam int unsigned SUM_W    = INT_W + 1;
  localparam int unsigned HOLD_GAP = 256;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_HOLD    = 2'd3
  } loop_state_t;

  localparam logic signed [SUM_W-1:0] DW_MAX  = SUM_W'((2 ** (DW - 1)) - 1);
  localparam logic signed [SUM_W-1:0] INT_MAX = SUM_W'((2 ** (INT_W - 1)) - 1);

  // Symmetric clamp: the most negative code is never produced.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [SUM_W-1:0] x);
    logic signed [SUM_W-1:0] y;
    y = x;
    if (x > DW_MAX) y = DW_MAX;
    else if (x < -DW_MAX) y = -DW_MAX;
    return DW'(y);
  endfunction

  function automatic logic signed [INT_W-1:0] sat_int(input logic signed [SUM_W-1:0] x);
    logic signed [SUM_W-1:0] y;
    y = x;
    if (x > INT_MAX) y = INT_MAX;
    else if (x < -INT_MAX) y = -INT_MAX;
    return INT_W'(y);
  endfunction

  // Magnitude as unsigned; -2^(DW-1) maps to 2^(DW-1) without overflow.
  function automatic logic [DW-1:0] abs_dw(input logic signed [DW-1:0] x);
    return x[DW-1] ? DW'(-x) : DW'(x);
  endfunction

endpackage

// File: rtl/carrier_lock_det.sv
// Lock detector: consecutive good/bad sample counters with threshold compares.
module carrier_lock_det
  import qpsk_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_THR   = 256,
  parameter int unsigned LOCK_CNT   = 64,
  parameter int unsigned UNLOCK_THR = 1024,
  parameter int unsigned UNLOCK_CNT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 valid_i,
  input  logic signed [DW-1:0] err_i,
  output logic                 lock_hit_c_o,
  output logic                 unlock_hit_c_o
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [GW-1:0] GOOD_MAX     = GW'(LOCK_CNT);
  localparam logic [BW-1:0] BAD_MAX      = BW'(UNLOCK_CNT);
  localparam logic [DW-1:0] LOCK_THR_W   = DW'(LOCK_THR);
  localparam logic [DW-1:0] UNLOCK_THR_W = DW'(UNLOCK_THR);

  logic [DW-1:0] err_abs;
  logic          good_c, bad_c;
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;

  assign err_abs = abs_dw(err_i);
  assign good_c  = err_abs < LOCK_THR_W;
  assign bad_c   = err_abs > UNLOCK_THR_W;

  // Hits fire on the sample that completes the run, not one cycle later.
  assign lock_hit_c_o   = valid_i && good_c && (good_q >= GW'(LOCK_CNT - 1));
  assign unlock_hit_c_o = valid_i && bad_c && (bad_q >= BW'(UNLOCK_CNT - 1));

  always_comb begin
    good_d = good_q;
    bad_d  = bad_q;
    if (clr_i) begin
      good_d = '0;
      bad_d  = '0;
    end else if (valid_i) begin
      good_d = !good_c ? '0 : ((good_q == GOOD_MAX) ? good_q : good_q + GW'(1));
      bad_d  = !bad_c  ? '0 : ((bad_q == BAD_MAX)   ? bad_q  : bad_q + BW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

endmodule

// File: rtl/carrier_loop_ctrl.sv
// QPSK carrier-recovery loop sequencer: PI loop filter, gain scheduling, lock/timeout FSM.
// Define CARRIER_HOLD_EN to add the HOLD state (TRACK with no samples for HOLD_GAP cycles).
module carrier_loop_ctrl
  import qpsk_ctrl_pkg::*;
#(
  parameter int unsigned INT_FRAC    = 4,
  parameter int unsigned KP_ACQ      = 2,
  parameter int unsigned KI_ACQ      = 6,
  parameter int unsigned KP_TRK      = 4,
  parameter int unsigned KI_TRK      = 10,
  parameter int unsigned LOCK_THR    = 256,
  parameter int unsigned LOCK_CNT    = 64,
  parameter int unsigned UNLOCK_THR  = 1024,
  parameter int unsigned UNLOCK_CNT  = 16,
  parameter int unsigned ACQ_TIMEOUT = 65535
) (
  input  logic                 clk_8megahz,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic signed [DW-1:0] err_data,
  input  logic                 err_valid,
  output logic signed [DW-1:0] nco_ctrl,
  output logic                 nco_clear,
  output logic                 locked,
  output logic                 lock_lost,
  output logic [1:0]           loop_state
);

  localparam int unsigned TW = $clog2(ACQ_TIMEOUT + 1);

  loop_state_t             state_q, state_d;
  logic signed [INT_W-1:0] integ_q, integ_new;
  logic signed [DW-1:0]    nco_q, nco_new;
  logic [TW-1:0]           timer_q;
  logic                    nco_clear_q, locked_q, lock_lost_q;
  logic                    sample_c, timeout_c, restart_c, clr_c;
  logic                    lock_hit_c, unlock_hit_c;
  logic signed [SUM_W-1:0] err_x, p_term, i_term, integ_sum, nco_sum;

  assign sample_c  = enable && err_valid && (state_q != ST_IDLE);
  assign timeout_c = (state_q == ST_ACQUIRE) && (timer_q == TW'(ACQ_TIMEOUT - 1));

  // PI filter; gains follow the state the sample arrives in (HOLD uses tracking gains).
  assign err_x     = SUM_W'(err_data);
  assign p_term    = (state_q == ST_ACQUIRE) ? (err_x >>> KP_ACQ) : (err_x >>> KP_TRK);
  assign i_term    = (state_q == ST_ACQUIRE) ? (err_x >>> KI_ACQ) : (err_x >>> KI_TRK);
  assign integ_sum = SUM_W'(integ_q) + i_term;
  assign integ_new = sat_int(integ_sum);
  assign nco_sum   = p_term + SUM_W'(integ_new >>> INT_FRAC);
  assign nco_new   = sat_dw(nco_sum);

`ifdef CARRIER_HOLD_EN
  localparam int unsigned HW = $clog2(HOLD_GAP + 1);
  logic [HW-1:0] hold_q;
  logic          gap_c;
  assign gap_c = (hold_q == HW'(HOLD_GAP - 1)) && !sample_c;
`endif

  carrier_lock_det #(
    .LOCK_THR   (LOCK_THR),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_THR (UNLOCK_THR),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) u_lock_det (
    .clk            (clk_8megahz),
    .rst_n          (rst_n),
    .clr_i          (clr_c),
    .valid_i        (sample_c),
    .err_i          (err_data),
    .lock_hit_c_o   (lock_hit_c),
    .unlock_hit_c_o (unlock_hit_c)
  );

  // Next state; disable overrides everything, lock beats a coincident timeout.
  always_comb begin
    state_d   = state_q;
    restart_c = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (lock_hit_c)     state_d = ST_TRACK;
          else if (timeout_c) restart_c = 1'b1;
        end
        ST_TRACK: begin
          if (unlock_hit_c) state_d = ST_ACQUIRE;
`ifdef CARRIER_HOLD_EN
          else if (gap_c)   state_d = ST_HOLD;
`endif
        end
`ifdef CARRIER_HOLD_EN
        ST_HOLD:    if (sample_c) state_d = ST_TRACK;
`endif
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  assign clr_c = (state_d != state_q) || restart_c;

  always_ff @(posedge clk_8megahz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      integ_q     <= '0;
      nco_q       <= '0;
      timer_q     <= '0;
      nco_clear_q <= 1'b0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nco_clear_q <= ((state_q == ST_IDLE) && (state_d == ST_ACQUIRE)) || restart_c;
      lock_lost_q <= (state_q == ST_TRACK) && (state_d == ST_ACQUIRE);
      locked_q    <= (state_d == ST_TRACK) || (state_d == ST_HOLD);
      if (!enable || (state_q == ST_IDLE) || restart_c) integ_q <= '0;
      else if (sample_c)                                integ_q <= integ_new;
      if (!enable)       nco_q <= '0;
      else if (sample_c) nco_q <= nco_new;
      if ((state_q == ST_ACQUIRE) && (state_d == ST_ACQUIRE) && !restart_c)
        timer_q <= timer_q + TW'(1);
      else
        timer_q <= '0;
    end
  end

`ifdef CARRIER_HOLD_EN
  // Idle-gap counter for entering HOLD.
  always_ff @(posedge clk_8megahz or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else if ((state_q == ST_TRACK) && (state_d == ST_TRACK) && !sample_c) hold_q <= hold_q + HW'(1);
    else hold_q <= '0;
  end
`endif

  assign nco_ctrl   = nco_q;
  assign nco_clear  = nco_clear_q;
  assign locked     = locked_q;
  assign lock_lost  = lock_lost_q;
  assign loop_state = state_q;

endmodule
